regfile_seq_ctrl: RTL

//  Sequencer that owns the ports of the 8x16 register file (regfile): after reset it

---
 rtl/regfile_seq_ctrl_if.sv | 36 +++
 rtl/regfile_seq_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_seq_ctrl_if.sv
// Micro-op handshake channel plus the 8x16 register file port bundle for regfile_seq_ctrl.
// The master side is the front-end together with the regfile; the slave side is the sequencer.
interface regfile_seq_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [AW-1:0] in_dst;
  logic [AW-1:0] in_srca;
  logic [AW-1:0] in_srcb;
  logic [DW-1:0] in_imm;

  logic [AW-1:0] AA;
  logic [AW-1:0] BA;
  logic [DW-1:0] AD;
  logic [DW-1:0] BD;
  logic [AW-1:0] DA;
  logic [DW-1:0] DD;
  logic          RW;

  modport master (
    output in_valid, in_op, in_dst, in_srca, in_srcb, in_imm,
    input  in_ready,
    input  AA, BA, DA, DD, RW,
    output AD, BD
  );

  modport slave (
    input  in_valid, in_op, in_dst, in_srca, in_srcb, in_imm,
    output in_ready,
    output AA, BA, DA, DD, RW,
    input  AD, BD
  );
endinterface

// File: rtl/regfile_seq_ctrl.sv
// Sole master of the register file: clears it after reset or on request, then runs
// one micro-op at a time as READ -> EXEC -> WRITE with back-to-back acceptance in WRITE.
module regfile_seq_ctrl #(
  parameter int DW      = 16,
  parameter int AW      = 3,
  parameter int INIT_EN = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              init_req,
  regfile_seq_ctrl_if.slave bus,
  output logic              done,
  output logic [DW-1:0]     result,
  output logic              zero,
  output logic              carry,
  output logic              init_done
);

  localparam int            NREG     = 1 << AW;
  localparam logic [AW-1:0] CNT_LAST = AW'(NREG - 1);
  localparam logic [AW-1:0] CNT_ONE  = AW'(1);
  localparam bit            INIT_ON  = (INIT_EN != 32'sd0);

  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_LDI = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_NOP = 4'd10;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_READ  = 3'd2,
    S_EXEC  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  localparam state_t S_RST = INIT_ON ? S_INIT : S_IDLE;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [AW-1:0] cnt_r;
  logic [3:0]    op_r;
  logic [AW-1:0] dst_r;
  logic [AW-1:0] aa_r;
  logic [AW-1:0] ba_r;
  logic [DW-1:0] imm_r;
  logic [DW-1:0] opa_r;
  logic [DW-1:0] opb_r;
  logic [AW-1:0] da_r;
  logic [DW-1:0] dd_r;
  logic [DW-1:0] result_r;
  logic          zero_r;
  logic          carry_r;
  logic          init_done_r;

  logic          init_go_s;
  logic          ready_s;
  logic          accept_s;
  logic          is_nop_s;
  logic          rw_s;
  logic [DW:0]   alu_s;

  // Returns {carry, result}; arithmetic wraps at DW bits.
  function automatic logic [DW:0] alu_f(input logic [3:0]    op,
                                        input logic [DW-1:0] a,
                                        input logic [DW-1:0] b,
                                        input logic [DW-1:0] imm);
    logic [DW:0] res;
    case (op)
      OP_MOV:  res = {1'b0, a};
      OP_ADD:  res = {1'b0, a} + {1'b0, b};
      OP_SUB:  res = {(a < b), a - b};
      OP_AND:  res = {1'b0, a & b};
      OP_OR:   res = {1'b0, a | b};
      OP_XOR:  res = {1'b0, a ^ b};
      OP_NOT:  res = {1'b0, ~a};
      OP_LDI:  res = {1'b0, imm};
      OP_SHL:  res = {a[DW-1], a[DW-2:0], 1'b0};
      OP_SHR:  res = {a[0], 1'b0, a[DW-1:1]};
      default: res = {1'b0, a};
    endcase
    return res;
  endfunction

  assign init_go_s = INIT_ON && init_req && (state_r == S_IDLE);
  // A pending re-clear wins over a micro-op, so IDLE withholds ready while it is requested.
  assign ready_s   = (state_r == S_WRITE) || ((state_r == S_IDLE) && !init_go_s);
  assign accept_s  = bus.in_valid && ready_s;
  assign is_nop_s  = (op_r >= OP_NOP);
  assign rw_s      = (state_r == S_INIT) || ((state_r == S_WRITE) && !is_nop_s);
  assign alu_s     = alu_f(op_r, opa_r, opb_r, imm_r);

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= S_RST;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_INIT: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_INIT;
        end
      end
      S_IDLE: begin
        if (init_go_s) begin
          state_nxt_s = S_INIT;
        end else if (accept_s) begin
          state_nxt_s = S_READ;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_READ:  state_nxt_s = S_EXEC;
      S_EXEC:  state_nxt_s = S_WRITE;
      S_WRITE: begin
        if (accept_s) begin
          state_nxt_s = S_READ;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      default: state_nxt_s = S_RST;
    endcase
  end

  // Operand capture, ALU result/flags, write-port address/data and the clear counter.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_r       <= '0;
      op_r        <= 4'd0;
      dst_r       <= '0;
      aa_r        <= '0;
      ba_r        <= '0;
      imm_r       <= '0;
      opa_r       <= '0;
      opb_r       <= '0;
      da_r        <= '0;
      dd_r        <= '0;
      result_r    <= '0;
      zero_r      <= 1'b0;
      carry_r     <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      if (accept_s) begin
        op_r  <= bus.in_op;
        dst_r <= bus.in_dst;
        aa_r  <= bus.in_srca;
        ba_r  <= bus.in_srcb;
        imm_r <= bus.in_imm;
      end
      case (state_r)
        S_INIT: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r       <= '0;
            init_done_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
            da_r  <= cnt_r + CNT_ONE;
          end
        end
        S_IDLE: begin
          // Without a clear phase the file is usable straight out of reset.
          if (!INIT_ON) begin
            init_done_r <= 1'b1;
          end
          if (init_go_s) begin
            cnt_r       <= '0;
            da_r        <= '0;
            dd_r        <= '0;
            init_done_r <= 1'b0;
          end
        end
        S_READ: begin
          opa_r <= bus.AD;
          opb_r <= bus.BD;
        end
        S_EXEC: begin
          if (!is_nop_s) begin
            result_r <= alu_s[DW-1:0];
            zero_r   <= (alu_s[DW-1:0] == '0);
            carry_r  <= alu_s[DW];
            da_r     <= dst_r;
            dd_r     <= alu_s[DW-1:0];
          end
        end
        S_WRITE: begin
          result_r <= result_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  // The write strobe is masked by RESET so a reset landing mid-op never commits a write.
  assign bus.RW       = RESET && rw_s;
  assign bus.in_ready = RESET && ready_s;
  assign bus.AA       = aa_r;
  assign bus.BA       = ba_r;
  assign bus.DA       = da_r;
  assign bus.DD       = dd_r;
  assign done         = (state_r == S_WRITE);
  assign result       = result_r;
  assign zero         = zero_r;
  assign carry        = carry_r;
  assign init_done    = init_done_r;

endmodule
